// File: rtl/uart_pkg.sv
// Shared receiver definitions: FSM state encoding and default baud/depth constants.
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz clock, 115200 baud
   localparam int DEFAULT_DEPTH_LOG2   = 4;    // 16-byte receive FIFO

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } rx_state_t;

endpackage

// File: rtl/rx_fifo.sv
// Byte FIFO with show-ahead read data, occupancy count and full/empty flags.
module rx_fifo #(
   parameter int DEPTH_LOG2 = uart_pkg::DEFAULT_DEPTH_LOG2
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                push,
   input  logic                pop,
   input  logic [7:0]          wdata,
   output logic [7:0]          rdata,
   output logic                full,
   output logic                empty,
   output logic [DEPTH_LOG2:0] count
);

   localparam int                  DEPTH     = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] COUNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty = (count == '0);
   assign full  = (count == COUNT_MAX);

   // A pop from an empty FIFO is ignored; a push into a full FIFO only lands
   // when a pop frees the head slot on the same edge.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Head byte is visible without a read strobe; forced to zero when empty.
   assign rdata = empty ? 8'h00 : mem[rd_ptr];

   // Storage write; contents are only meaningful between push and pop.
   // NOTE: the data array has no reset so it maps onto plain RAM; count and
   // pointers guard every read, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally modulo depth.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with input synchronizer, sticky error flags and a byte FIFO.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DEPTH_LOG2   = DEFAULT_DEPTH_LOG2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rxd,
   input  logic       rd_en,
   input  logic       clr_err,
   output logic       Rx_ready,
   output logic [7:0] rdata,
   output logic       overrun,
   output logic       frame_err
);

   // Counter reload values. The start-bit sample lands CLKS_PER_BIT/2 cycles
   // after the synchronized falling edge is first visible; the load happens one
   // edge after that and the sample fires one edge after the count hits zero.
   localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 2);
   localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);

   logic [1:0]          sync;
   logic                rxd_s;
   rx_state_t           state, state_d;
   logic [15:0]         cnt, cnt_d;
   logic [2:0]          bit_idx, bit_idx_d;
   logic [7:0]          shift, shift_d;
   logic                push;
   logic                frame_set;
   logic                overrun_set;
   logic                fifo_full;
   logic                fifo_empty;
   logic [DEPTH_LOG2:0] fifo_count;

   assign rxd_s = sync[1];

   // Two-flop synchronizer; idle-high reset value avoids a false start bit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) sync <= 2'b11;
      else       sync <= {sync[0], rxd};
   end

   // Receiver state, bit-period counter, bit index and shift register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         bit_idx <= bit_idx_d;
         shift   <= shift_d;
      end
   end

   // Next-state logic: count down to each mid-bit sample point.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      bit_idx_d = bit_idx;
      shift_d   = shift;
      push      = 1'b0;
      frame_set = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rxd_s) begin
               state_d = ST_START;
               cnt_d   = HALF_LOAD;
            end
         end
         ST_START: begin
            if (cnt != '0) begin
               cnt_d = cnt - 16'd1;
            end else if (rxd_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d   = ST_DATA;
               cnt_d     = FULL_LOAD;
               bit_idx_d = 3'd0;
            end
         end
         ST_DATA: begin
            if (cnt != '0) begin
               cnt_d = cnt - 16'd1;
            end else begin
               shift_d = {rxd_s, shift[7:1]};
               cnt_d   = FULL_LOAD;
               if (bit_idx == 3'd7) state_d   = ST_STOP;
               else                 bit_idx_d = bit_idx + 3'd1;
            end
         end
         ST_STOP: begin
            if (cnt != '0) begin
               cnt_d = cnt - 16'd1;
            end else if (rxd_s) begin
               push    = 1'b1;
               state_d = ST_IDLE;
            end else begin
               frame_set = 1'b1;
               state_d   = ST_BREAK;
            end
         end
         ST_BREAK: begin
            if (rxd_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A byte is dropped only when full and no pop frees a slot on this edge.
   assign overrun_set = push && fifo_full && !rd_en;

   // Sticky error flags; a set event outranks a simultaneous clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (overrun_set)  overrun <= 1'b1;
         else if (clr_err) overrun <= 1'b0;
         if (frame_set)    frame_err <= 1'b1;
         else if (clr_err) frame_err <= 1'b0;
      end
   end

   rx_fifo #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_fifo (
      .clk  (clk),
      .rstn (rstn),
      .push (push),
      .pop  (rd_en),
      .wdata(shift),
      .rdata(rdata),
      .full (fifo_full),
      .empty(fifo_empty),
      .count(fifo_count)
   );

   assign Rx_ready = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit and a 16-entry FIFO.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rstn;
   logic       rxd;
   logic       rd_en;
   logic       clr_err;
   logic       Rx_ready;
   logic [7:0] rdata;
   logic       overrun;
   logic       frame_err;

   int checks   = 0;
   int failures = 0;
   int rise_at;

   uart_rx_fifo #(
      .CLKS_PER_BIT(CPB),
      .DEPTH_LOG2  (4)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .rxd      (rxd),
      .rd_en    (rd_en),
      .clr_err  (clr_err),
      .Rx_ready (Rx_ready),
      .rdata    (rdata),
      .overrun  (overrun),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle 1 ns past the edge before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Drive one 8N1 frame. rise_at records the first cycle (counted from the
   // start-bit drive) at which Rx_ready is seen high. With pop_at_stop set,
   // rd_en is high exactly on the stop-sample edge (cycle 154).
   task automatic send_byte(input logic [7:0] b, input logic stop_val, input bit pop_at_stop);
      int n;
      n       = 0;
      rise_at = -1;
      for (int bit_i = 0; bit_i < 10; bit_i++) begin
         if (bit_i == 0)      rxd = 1'b0;
         else if (bit_i == 9) rxd = stop_val;
         else                 rxd = b[bit_i-1];
         for (int k = 0; k < CPB; k++) begin
            tick();
            n++;
            if (pop_at_stop && bit_i == 9 && k == 8) rd_en = 1'b1;
            if (pop_at_stop && bit_i == 9 && k == 9) rd_en = 1'b0;
            if (Rx_ready && rise_at < 0) rise_at = n;
         end
      end
   endtask

   task automatic pop_byte(input string tag, input logic [7:0] exp);
      check({tag, "_ready"}, 32'(Rx_ready), 32'd1);
      check({tag, "_data"}, 32'(rdata), 32'(exp));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      rstn    = 1'b0;
      rxd     = 1'b1;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      #1;
      check("rst_ready", 32'(Rx_ready), 32'd0);
      check("rst_rdata", 32'(rdata), 32'h00);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_frame", 32'(frame_err), 32'd0);
      idle(3);
      @(negedge clk);
      rstn = 1'b1;
      idle(5);

      // Single byte: latency 2 sync + 8 half-bit + 9 full bits = 154 cycles.
      send_byte(8'hA5, 1'b1, 1'b0);
      check("a5_latency", 32'(rise_at), 32'd154);
      check("a5_count", 32'(dut.fifo_count), 32'd1);
      pop_byte("a5", 8'hA5);
      check("a5_empty_after_pop", 32'(Rx_ready), 32'd0);

      // Pop while empty is ignored.
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("empty_pop_count", 32'(dut.fifo_count), 32'd0);
      check("empty_pop_ready", 32'(Rx_ready), 32'd0);

      // Fill to 16, then overflow with 8'hFF.
      for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, 1'b0);
      check("fill_count", 32'(dut.fifo_count), 32'd16);
      check("fill_no_overrun", 32'(overrun), 32'd0);
      send_byte(8'hFF, 1'b1, 1'b0);
      check("ovf_overrun", 32'(overrun), 32'd1);
      check("ovf_count", 32'(dut.fifo_count), 32'd16);
      for (int i = 0; i < 16; i++) pop_byte("fill_pop", 8'(i));
      check("drain_ready", 32'(Rx_ready), 32'd0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("clr_overrun", 32'(overrun), 32'd0);

      // Second fill through wrapped pointers, then push+pop while full.
      for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i), 1'b1, 1'b0);
      check("refill_count", 32'(dut.fifo_count), 32'd16);
      send_byte(8'h77, 1'b1, 1'b1);
      check("full_pushpop_count", 32'(dut.fifo_count), 32'd16);
      check("full_pushpop_overrun", 32'(overrun), 32'd0);
      for (int i = 1; i < 16; i++) pop_byte("refill_pop", 8'h80 + 8'(i));
      pop_byte("last_77", 8'h77);
      check("refill_drained", 32'(Rx_ready), 32'd0);

      // Short glitch on rxd: no push, back to IDLE, no framing error.
      rxd = 1'b0;
      idle(3);
      rxd = 1'b1;
      idle(40);
      check("glitch_ready", 32'(Rx_ready), 32'd0);
      check("glitch_state", 32'(dut.state), 32'(ST_IDLE));
      check("glitch_frame", 32'(frame_err), 32'd0);

      // Framing error, break hold, recovery.
      send_byte(8'h3C, 1'b0, 1'b0);
      check("ferr_flag", 32'(frame_err), 32'd1);
      check("ferr_no_push", 32'(dut.fifo_count), 32'd0);
      idle(100);
      check("break_hold", 32'(dut.state), 32'(ST_BREAK));
      rxd = 1'b1;
      idle(20);
      check("break_exit", 32'(dut.state), 32'(ST_IDLE));
      // Push with a simultaneous pop on an empty FIFO: pop ignored.
      send_byte(8'h11, 1'b1, 1'b1);
      check("empty_pushpop_count", 32'(dut.fifo_count), 32'd1);
      check("ferr_still_set", 32'(frame_err), 32'd1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("clr_frame", 32'(frame_err), 32'd0);
      pop_byte("rx_11", 8'h11);

      // Async reset during DATA of 8'h5A with a byte already queued.
      send_byte(8'h42, 1'b1, 1'b0);
      check("pre_rst_ready", 32'(Rx_ready), 32'd1);
      rxd = 1'b0;
      idle(CPB);
      rxd = 1'b0;
      idle(CPB);
      rxd = 1'b1;
      idle(CPB);
      #2;
      rstn = 1'b0;
      #1;
      check("midrst_ready", 32'(Rx_ready), 32'd0);
      check("midrst_rdata", 32'(rdata), 32'h00);
      check("midrst_state", 32'(dut.state), 32'(ST_IDLE));
      rxd = 1'b1;
      idle(4);
      @(negedge clk);
      rstn = 1'b1;
      idle(30);
      send_byte(8'hC3, 1'b1, 1'b0);
      check("post_rst_count", 32'(dut.fifo_count), 32'd1);
      check("post_rst_frame", 32'(frame_err), 32'd0);
      pop_byte("rx_c3", 8'hC3);
      check("final_empty", 32'(Rx_ready), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
